sdram_pattern_master: RTL

//  Avalon-MM master on the SDRAM controller's s1 slave port inside the Qsys system. It fills a

---
 rtl/sdram_test_pkg.sv | 28 ++
 rtl/sdram_pattern_gen.sv | 46 ++++
 rtl/sdram_pattern_master.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sdram_test_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : sdram_test_pkg
//  Description : Shared state encoding, pattern selects and LFSR constants
//                for the SDRAM pattern test master.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [1:0] PAT_ADDR  = 2'd0;
    localparam logic [1:0] PAT_INV   = 2'd1;
    localparam logic [1:0] PAT_LFSR  = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form taps bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage
`default_nettype wire

// File: rtl/sdram_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pattern_gen
//  Description : Per-word 16-bit test pattern source (address, inverted
//                address, LFSR, checkerboard), advanced one word per step.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_pattern_gen
    import sdram_test_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        step,
    input  logic [1:0]  sel,
    output logic [15:0] data
);

    logic [15:0] r_idx;
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx  <= '0;
            r_lfsr <= LFSR_SEED;
        end else if (load) begin
            r_idx  <= '0;
            r_lfsr <= LFSR_SEED;
        end else if (step) begin
            r_idx  <= r_idx + 16'd1;
            r_lfsr <= {^(r_lfsr & LFSR_TAPS), r_lfsr[15:1]};
        end
    end

    always_comb begin
        data = r_idx;
        case (sel)
            PAT_ADDR: data = r_idx;
            PAT_INV:  data = ~r_idx;
            PAT_LFSR: data = r_lfsr;
            default:  data = r_idx[0] ? 16'hAAAA : 16'h5555;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sdram_pattern_master.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_pattern_master
//  Description : Avalon-MM master that fills an SDRAM region with a pattern,
//                reads it back with pipelined reads and counts mismatches.
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_pattern_master
    import sdram_test_pkg::*;
#(
    parameter int ADDR_W   = 26,
    parameter int DATA_W   = 16,
    parameter int MAX_PEND = 8,
    parameter int LEN_W    = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        pattern_sel,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    output logic [1:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    localparam int                 c_pend_w   = $clog2(MAX_PEND) + 1;
    localparam logic [c_pend_w-1:0] c_max_pend = c_pend_w'(MAX_PEND);

    state_e              r_state;
    state_e              w_state_nxt;
    logic                r_start_d;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_first_err;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_idx;
    logic [LEN_W-1:0]    r_rx_idx;
    logic [1:0]          r_sel;
    logic [c_pend_w-1:0] r_pend;
    logic [15:0]         r_err;
    logic                r_found;

    logic                w_start_rise;
    logic                w_go;
    logic                w_wr_acc;
    logic                w_rd_acc;
    logic                w_rdv;
    logic                w_idx_last;
    logic [15:0]         w_wr_pat;
    logic [15:0]         w_rx_pat;

    assign w_start_rise = start & ~r_start_d;
    assign w_idx_last   = (r_idx + LEN_W'(1)) == r_len;
    assign w_wr_acc     = avm_write & ~avm_waitrequest;
    assign w_rd_acc     = avm_read & ~avm_waitrequest;
    // Responses only count while a run is reading; stragglers after an abort are dropped
    assign w_rdv        = avm_readdatavalid && (r_pend != '0) &&
                          ((r_state == ST_READ) || (r_state == ST_DRAIN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        avm_write   = 1'b0;
        avm_read    = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_rise) begin
                    w_go        = 1'b1;
                    w_state_nxt = (length == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                avm_write = 1'b1;
                if (!avm_waitrequest && w_idx_last) w_state_nxt = ST_READ;
            end
            ST_READ: begin
                // Pending only falls while stalled, so an issued read stays asserted
                avm_read = (r_idx < r_len) && (r_pend < c_max_pend);
                if (avm_read && !avm_waitrequest && w_idx_last) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_pend == '0) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_start_d   <= 1'b0;
            r_base      <= '0;
            r_len       <= '0;
            r_sel       <= '0;
            r_idx       <= '0;
            r_rx_idx    <= '0;
            r_pend      <= '0;
            r_err       <= '0;
            r_first_err <= '0;
            r_found     <= 1'b0;
        end else begin
            r_start_d <= start;
            if (w_go) begin
                r_base      <= base_addr & ~ADDR_W'(1);
                r_len       <= length;
                r_sel       <= pattern_sel;
                r_idx       <= '0;
                r_rx_idx    <= '0;
                r_pend      <= '0;
                r_err       <= '0;
                r_first_err <= '0;
                r_found     <= 1'b0;
            end else begin
                if (w_wr_acc) r_idx <= w_idx_last ? '0 : r_idx + LEN_W'(1);
                if (w_rd_acc) r_idx <= r_idx + LEN_W'(1);

                if (w_rd_acc && !w_rdv)      r_pend <= r_pend + c_pend_w'(1);
                else if (!w_rd_acc && w_rdv) r_pend <= r_pend - c_pend_w'(1);

                if (w_rdv) begin
                    if (avm_readdata != w_rx_pat) begin
                        if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
                        if (!r_found) begin
                            r_found     <= 1'b1;
                            r_first_err <= r_base + ADDR_W'({r_rx_idx, 1'b0});
                        end
                    end
                    r_rx_idx <= r_rx_idx + LEN_W'(1);
                end
            end
        end
    end

    // Separate generators keep the issue-side and compare-side LFSR sequences independent
    sdram_pattern_gen u_gen_wr (
        .clk   (clk),
        .reset (reset),
        .load  (w_go),
        .step  (w_wr_acc),
        .sel   (r_sel),
        .data  (w_wr_pat)
    );

    sdram_pattern_gen u_gen_rx (
        .clk   (clk),
        .reset (reset),
        .load  (w_go),
        .step  (w_rdv),
        .sel   (r_sel),
        .data  (w_rx_pat)
    );

    assign avm_address    = r_base + ADDR_W'({r_idx, 1'b0});
    assign avm_writedata  = DATA_W'(w_wr_pat);
    assign avm_byteenable = {2{avm_read | avm_write}};
    assign busy           = (r_state == ST_WRITE) || (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign done           = (r_state == ST_DONE);
    assign fail           = done && (r_err != 16'd0);
    assign err_count      = r_err;
    assign first_err_addr = r_first_err;

endmodule
`default_nettype wire
